// File: rtl/mu_sweep_pkg.sv
// mu_sweep_pkg: shared definitions for the delay-code sweep sequencer.
//   - state_e       : sequencer FSM states
//   - REG_*         : register offsets decoded from wb adr[4:2]
//   - CTRL_*/STAT_* : bit positions inside CTRL and STATUS
//   - pack_entry()  : result FIFO entry layout {code[31:16], hits[15:0]}
package mu_sweep_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_REQ,
    S_ACC,
    S_PUSH,
    S_DONE
  } state_e;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_RANGE  = 3'd2;
  localparam logic [2:0] REG_CFG    = 3'd3;
  localparam logic [2:0] REG_FIFO   = 3'd4;

  localparam int CTRL_START   = 0;
  localparam int CTRL_ABORT   = 1;
  localparam int CTRL_IRQ_EN  = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_FULL    = 2;
  localparam int STAT_DONE    = 3;
  localparam int STAT_CNT_LSB = 8;

  // Code is zero-extended by the caller, so a 10-bit code lands in [25:16].
  function automatic logic [31:0] pack_entry(input logic [15:0] code,
                                             input logic [15:0] hits);
    return {code, hits};
  endfunction

endpackage

// File: rtl/mu_sweep_if.sv
// mu_sweep_if: Wishbone classic bus bundle for the sweep sequencer.
//   master drives cyc, stb, we, adr (byte address), dat_w, sel
//   slave  drives dat_r, ack, stall, err
interface mu_sweep_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [3:0]  sel;
  logic [31:0] dat_r;
  logic        ack;
  logic        stall;
  logic        err;

  modport master (output cyc, stb, we, adr, dat_w, sel,
                  input  dat_r, ack, stall, err);
  modport slave  (input  cyc, stb, we, adr, dat_w, sel,
                  output dat_r, ack, stall, err);
endinterface

// File: rtl/mu_sweep_fifo.sv
// mu_sweep_fifo: synchronous FIFO with occupancy count.
//   clk_i, rst_i (sync, active-high) ; push_i/din_i write ; pop_i reads
//   dout_o shows the head entry ; full_o, empty_o, count_o status.
// Push while full and pop while empty are dropped; push and pop in the
// same cycle are both performed. DEPTH must be a power of 2, >= 2.
module mu_sweep_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset; pointers/count define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/mu_sweep_ctrl.sv
// mu_sweep_ctrl: Wishbone-slave sequencer that sweeps the measure unit's
// delay code from start to stop, takes reps measurements per point, counts
// comparator hits and queues {code, hits} in a result FIFO.
// Ports:
//   wb_clk_i, wb_rst_i (sync, active-high)
//   wb            : mu_sweep_if.slave (cyc/stb/we/adr/dat_w/sel -> dat_r/ack,
//                   stall and err tied 0); only adr[4:2] decoded, sel ignored
//   delay_code_o  : current sweep code
//   meas_req_o    : request one strobe+compare; meas_done_i/meas_hit_i reply
//   busy_o        : sweep in progress ; irq_o : level interrupt
// Build option: define MU_SWEEP_IRQ_EN to enable CTRL.IRQ_EN and irq_o;
// otherwise irq_o is 0 and CTRL bit2 is read-as-zero.
module mu_sweep_ctrl
  import mu_sweep_pkg::*;
#(
  parameter int CODE_W        = 10,
  parameter int FIFO_DEPTH    = 16,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  mu_sweep_if.slave         wb,
  output logic [CODE_W-1:0] delay_code_o,
  output logic              meas_req_o,
  input  logic              meas_done_i,
  input  logic              meas_hit_i,
  output logic              busy_o,
  output logic              irq_o
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

  // bus side
  logic        ack_q;
  logic [31:0] dat_q, rdata, ctrl_rd;
  logic        acc, wr, rd;
  logic [2:0]  reg_sel;
  logic        start_cmd, abort_cmd;
  logic        start_pend_q, abort_pend_q, done_q;
  logic [CODE_W-1:0] start_code_q, stop_code_q, step_q, step_eff;
  logic [15:0] reps_q, reps_eff;

  // sequencer
  state_e            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [15:0]       hits_q, hits_d, rep_q, rep_d;
  logic [SET_W-1:0]  set_q, set_d;
  logic [CODE_W:0]   next_code;

  // fifo
  logic             f_push, f_pop, f_full, f_empty;
  logic [31:0]      f_din, f_dout;
  logic [CNT_W-1:0] f_count;

  logic unused_ok;
  assign unused_ok = ^{wb.sel, wb.adr, wb.dat_w};

  // A new access is accepted only while ack is low, so each access takes
  // two cycles and ack is a single-cycle pulse.
  assign acc     = wb.cyc & wb.stb & ~ack_q;
  assign wr      = acc & wb.we;
  assign rd      = acc & ~wb.we;
  assign reg_sel = wb.adr[4:2];

  assign start_cmd = wr && (reg_sel == REG_CTRL) && wb.dat_w[CTRL_START];
  assign abort_cmd = wr && (reg_sel == REG_CTRL) && wb.dat_w[CTRL_ABORT];

  assign wb.ack   = ack_q;
  assign wb.dat_r = dat_q;
  assign wb.stall = 1'b0;
  assign wb.err   = 1'b0;

  assign step_eff  = (step_q == '0) ? CODE_W'(1) : step_q;
  assign reps_eff  = (reps_q == '0) ? 16'd1 : reps_q;
  // One extra bit so a step past the top of the code range cannot wrap.
  assign next_code = {1'b0, code_q} + {1'b0, step_eff};

  assign busy_o       = (state_q != S_IDLE);
  assign meas_req_o   = (state_q == S_REQ);
  assign delay_code_o = code_q;

`ifdef MU_SWEEP_IRQ_EN
  logic irq_en_q;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)                        irq_en_q <= 1'b0;
    else if (wr && reg_sel == REG_CTRL)  irq_en_q <= wb.dat_w[CTRL_IRQ_EN];
  end
  assign irq_o   = irq_en_q & (done_q | f_full);
  assign ctrl_rd = 32'(irq_en_q) << CTRL_IRQ_EN;
`else
  assign irq_o   = 1'b0;
  assign ctrl_rd = '0;
`endif

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_CTRL: rdata = ctrl_rd;
      REG_STATUS: begin
        rdata[STAT_BUSY]            = busy_o;
        rdata[STAT_EMPTY]           = f_empty;
        rdata[STAT_FULL]            = f_full;
        rdata[STAT_DONE]            = done_q;
        rdata[STAT_CNT_LSB +: 8]    = 8'(f_count);
      end
      REG_RANGE: rdata = 32'(start_code_q) | (32'(stop_code_q) << 16);
      REG_CFG:   rdata = 32'(step_q) | {reps_q, 16'h0000};
      REG_FIFO:  rdata = f_empty ? '0 : f_dout;
      default:   ;
    endcase
  end

  assign f_pop = rd && (reg_sel == REG_FIFO) && !f_empty;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q        <= 1'b0;
      dat_q        <= '0;
      start_pend_q <= 1'b0;
      abort_pend_q <= 1'b0;
      done_q       <= 1'b0;
      start_code_q <= '0;
      stop_code_q  <= '0;
      step_q       <= '0;
      reps_q       <= '0;
    end else begin
      ack_q        <= acc;
      dat_q        <= rd ? rdata : '0;
      // Commands act one cycle after the ack edge; abort beats start.
      start_pend_q <= start_cmd & ~abort_cmd;
      abort_pend_q <= abort_cmd;
      if (wr && reg_sel == REG_RANGE) begin
        start_code_q <= wb.dat_w[CODE_W-1:0];
        stop_code_q  <= wb.dat_w[16 +: CODE_W];
      end
      if (wr && reg_sel == REG_CFG) begin
        step_q <= wb.dat_w[CODE_W-1:0];
        reps_q <= wb.dat_w[31:16];
      end
      if (state_q == S_DONE && !abort_pend_q)
        done_q <= 1'b1;
      else if (wr && reg_sel == REG_STATUS && wb.dat_w[STAT_DONE])
        done_q <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      code_q  <= '0;
      hits_q  <= '0;
      rep_q   <= '0;
      set_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      hits_q  <= hits_d;
      rep_q   <= rep_d;
      set_q   <= set_d;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    hits_d  = hits_q;
    rep_d   = rep_q;
    set_d   = set_q;
    f_push  = 1'b0;
    if (abort_pend_q) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_pend_q) begin
            if (start_code_q <= stop_code_q) begin
              code_d  = start_code_q;
              hits_d  = '0;
              rep_d   = '0;
              set_d   = '0;
              state_d = S_SETTLE;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_SETTLE: begin
          if (set_q == SETTLE_LAST) state_d = S_REQ;
          else                      set_d   = set_q + SET_W'(1);
        end
        S_REQ: begin
          if (meas_done_i) begin
            hits_d  = hits_q + 16'(meas_hit_i);
            rep_d   = rep_q + 16'd1;
            state_d = S_ACC;
          end
        end
        S_ACC: state_d = (rep_q < reps_eff) ? S_REQ : S_PUSH;
        S_PUSH: begin
          if (!f_full) begin
            f_push = 1'b1;
            if (next_code > {1'b0, stop_code_q}) begin
              state_d = S_DONE;
            end else begin
              code_d  = next_code[CODE_W-1:0];
              hits_d  = '0;
              rep_d   = '0;
              set_d   = '0;
              state_d = S_SETTLE;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign f_din = pack_entry(16'(code_q), hits_q);

  mu_sweep_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .push_i  (f_push),
    .pop_i   (f_pop),
    .din_i   (f_din),
    .dout_o  (f_dout),
    .full_o  (f_full),
    .empty_o (f_empty),
    .count_o (f_count)
  );

endmodule

// File: tb/tb_mu_sweep_ctrl.sv
module tb_mu_sweep_ctrl;
  import mu_sweep_pkg::*;

  localparam int SETTLE = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mu_sweep_if wb();
  logic [9:0] delay_code;
  logic       meas_req, meas_done, meas_hit, busy, irq;

  int errors = 0;
  int checks = 0;

  // measure-unit model controls
  int         hit_mode = 0;   // 0 never hit, 1 always hit, 2 alternate
  logic       toggle = 1'b0;
  bit         hold_en = 1'b0;
  logic [9:0] hold_code = '0;
  int         req_cycles = 0;
  bit         irq_seen = 1'b0;

  mu_sweep_ctrl dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .wb           (wb),
    .delay_code_o (delay_code),
    .meas_req_o   (meas_req),
    .meas_done_i  (meas_done),
    .meas_hit_i   (meas_hit),
    .busy_o       (busy),
    .irq_o        (irq)
  );

  // Measure unit: answers a request after 3 sampled cycles, unless held.
  initial begin
    int lat;
    lat = 0;
    meas_done = 1'b0;
    meas_hit  = 1'b0;
    forever begin
      @(posedge clk); #1;
      meas_done = 1'b0;
      meas_hit  = 1'b0;
      if (irq) irq_seen = 1'b1;
      if (meas_req) begin
        req_cycles++;
        if (hold_en && delay_code == hold_code) lat = 0;
        else if (lat == 2) begin
          meas_done = 1'b1;
          meas_hit  = (hit_mode == 1) ? 1'b1 : (hit_mode == 2) ? toggle : 1'b0;
          toggle    = ~toggle;
          lat       = 0;
        end else lat++;
      end else lat = 0;
    end
  end

  task automatic wb_xfer(input logic we, input logic [2:0] r,
                         input logic [31:0] d, output logic [31:0] q);
    int n;
    @(posedge clk); #1;
    wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = we;
    wb.adr = {27'b0, r, 2'b00}; wb.dat_w = d; wb.sel = 4'hf;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!wb.ack && n < 8);
    q = wb.dat_r;
    if (!wb.ack) begin
      checks++; errors++;
      $display("FAIL wb_ack_timeout: ack=%b after %0d cycles, want 1", wb.ack, n);
    end
    wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
  endtask

  task automatic wb_write(input logic [2:0] r, input logic [31:0] d);
    logic [31:0] q;
    wb_xfer(1'b1, r, d, q);
  endtask

  task automatic wb_read(input logic [2:0] r, output logic [31:0] q);
    wb_xfer(1'b0, r, 32'h0, q);
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    repeat (2) @(posedge clk);
    #1;
    while (busy && n < max) begin @(posedge clk); #1; n++; end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, want 0", busy, max);
    end
  endtask

  task automatic test_reset();
    logic [31:0] q;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (wb.ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b want 0", wb.ack); end
    checks++; if (wb.dat_r !== 32'h0) begin errors++; $display("FAIL rst_dat: got %h want 0", wb.dat_r); end
    checks++; if (delay_code !== 10'd0) begin errors++; $display("FAIL rst_code: got %0d want 0", delay_code); end
    checks++; if (meas_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", meas_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b want 0", irq); end
    wb_read(REG_STATUS, q);
    checks++; if (q !== 32'h2) begin errors++; $display("FAIL rst_status: got %h want 00000002", q); end
    wb_write(3'd5, 32'hffff_ffff);
    wb_read(3'd5, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL reg5_read: got %h want 0", q); end
  endtask

  task automatic test_basic();
    logic [31:0] q;
    logic [31:0] exp [3];
    exp[0] = 32'h000A_0002; exp[1] = 32'h000F_0002; exp[2] = 32'h0014_0002;
    hit_mode = 2; toggle = 1'b0;
    wb_write(REG_RANGE, (32'd20 << 16) | 32'd10);
    wb_write(REG_CFG, (32'd4 << 16) | 32'd5);
    wb_read(REG_CFG, q);
    checks++; if (q !== 32'h0004_0005) begin errors++; $display("FAIL cfg_readback: got %h want 00040005", q); end
    wb_write(REG_CTRL, 32'h1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_ack: got %b want 0", busy); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_rise: got %b want 1", busy); end
    checks++; if (delay_code !== 10'd10) begin errors++; $display("FAIL code_first: got %0d want 10", delay_code); end
    repeat (SETTLE - 1) @(posedge clk);
    #1;
    checks++; if (meas_req !== 1'b0) begin errors++; $display("FAIL req_early: got %b want 0", meas_req); end
    @(posedge clk); #1;
    checks++; if (meas_req !== 1'b1) begin errors++; $display("FAIL req_on_time: got %b want 1", meas_req); end
    wait_idle(2000);
    wb_read(REG_STATUS, q);
    checks++; if (q !== 32'h0000_0308) begin errors++; $display("FAIL basic_status: got %h want 00000308", q); end
    for (int i = 0; i < 3; i++) begin
      wb_read(REG_FIFO, q);
      checks++; if (q !== exp[i]) begin errors++; $display("FAIL basic_entry%0d: got %h want %h", i, q, exp[i]); end
    end
    wb_read(REG_FIFO, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL empty_read: got %h want 0", q); end
    wb_write(REG_STATUS, 32'h8);
    wb_read(REG_STATUS, q);
    checks++; if (q !== 32'h2) begin errors++; $display("FAIL done_clear: got %h want 00000002", q); end
  endtask

  task automatic test_no_wrap();
    logic [31:0] q;
    hit_mode = 1;
    wb_write(REG_RANGE, (32'd1023 << 16) | 32'd1020);
    wb_write(REG_CFG, (32'd1 << 16) | 32'd8);
    wb_write(REG_CTRL, 32'h1);
    wait_idle(2000);
    checks++; if (delay_code !== 10'd1020) begin errors++; $display("FAIL nowrap_code: got %0d want 1020", delay_code); end
    wb_read(REG_STATUS, q);
    checks++; if (q !== 32'h0000_0108) begin errors++; $display("FAIL nowrap_status: got %h want 00000108", q); end
    wb_read(REG_FIFO, q);
    checks++; if (q !== 32'h03FC_0001) begin errors++; $display("FAIL nowrap_entry: got %h want 03fc0001", q); end
    wb_write(REG_STATUS, 32'h8);
  endtask

  task automatic test_fifo_full();
    logic [31:0] q;
    hit_mode = 1;
    wb_write(REG_RANGE, (32'd31 << 16) | 32'd0);
    wb_write(REG_CFG, (32'd1 << 16) | 32'd1);
    wb_write(REG_CTRL, 32'h1);
    repeat (600) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b want 1", busy); end
    checks++; if (delay_code !== 10'd16) begin errors++; $display("FAIL stall_code: got %0d want 16", delay_code); end
    wb_read(REG_STATUS, q);
    checks++; if (q !== 32'h0000_1005) begin errors++; $display("FAIL stall_status: got %h want 00001005", q); end
    for (int i = 0; i < 16; i++) begin
      wb_read(REG_FIFO, q);
      checks++; if (q !== ((32'(i) << 16) | 32'd1)) begin errors++; $display("FAIL full_first%0d: got %h want %h", i, q, (32'(i) << 16) | 32'd1); end
    end
    wait_idle(2000);
    wb_read(REG_STATUS, q);
    checks++; if (q !== 32'h0000_100C) begin errors++; $display("FAIL full_end_status: got %h want 0000100c", q); end
    for (int i = 16; i < 32; i++) begin
      wb_read(REG_FIFO, q);
      checks++; if (q !== ((32'(i) << 16) | 32'd1)) begin errors++; $display("FAIL full_second%0d: got %h want %h", i, q, (32'(i) << 16) | 32'd1); end
    end
    wb_write(REG_STATUS, 32'h8);
  endtask

  task automatic test_abort();
    logic [31:0] q;
    int n;
    hit_mode = 1; hold_en = 1'b1; hold_code = 10'd4;
    wb_write(REG_RANGE, (32'd10 << 16) | 32'd0);
    wb_write(REG_CFG, (32'd2 << 16) | 32'd2);
    wb_write(REG_CTRL, 32'h1);
    n = 0;
    while (!(meas_req && delay_code == 10'd4) && n < 1000) begin @(posedge clk); #1; n++; end
    checks++; if (!(meas_req && delay_code == 10'd4)) begin errors++; $display("FAIL abort_reach_point3: req=%b code=%0d want 1/4", meas_req, delay_code); end
    wb_write(REG_CTRL, 32'h2);
    @(posedge clk); #1;
    checks++; if (meas_req !== 1'b0) begin errors++; $display("FAIL abort_req: got %b want 0", meas_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    hold_en = 1'b0;
    wb_read(REG_STATUS, q);
    checks++; if (q !== 32'h0000_0200) begin errors++; $display("FAIL abort_status: got %h want 00000200", q); end
    wb_read(REG_FIFO, q);
    checks++; if (q !== 32'h0000_0002) begin errors++; $display("FAIL abort_entry0: got %h want 00000002", q); end
    wb_read(REG_FIFO, q);
    checks++; if (q !== 32'h0002_0002) begin errors++; $display("FAIL abort_entry1: got %h want 00020002", q); end
  endtask

  task automatic test_start_rules();
    logic [31:0] q;
    int r0;
    // start above stop: straight to done, no request
    r0 = req_cycles;
    wb_write(REG_RANGE, (32'd3 << 16) | 32'd5);
    wb_write(REG_CTRL, 32'h1);
    wait_idle(100);
    wb_read(REG_STATUS, q);
    checks++; if (q !== 32'h0000_000A) begin errors++; $display("FAIL gt_status: got %h want 0000000a", q); end
    checks++; if (req_cycles !== r0) begin errors++; $display("FAIL gt_req: got %0d req cycles want 0", req_cycles - r0); end
    wb_write(REG_STATUS, 32'h8);
    // start+abort together: abort wins
    wb_write(REG_RANGE, (32'd0 << 16) | 32'd0);
    wb_write(REG_CTRL, 32'h3);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_abort_busy: got %b want 0", busy); end
    checks++; if (req_cycles !== r0) begin errors++; $display("FAIL start_abort_req: got %0d req cycles want 0", req_cycles - r0); end
    // start while busy is ignored
    hit_mode = 1;
    wb_write(REG_RANGE, (32'd4 << 16) | 32'd0);
    wb_write(REG_CFG, (32'd1 << 16) | 32'd2);
    wb_write(REG_CTRL, 32'h1);
    repeat (3) wb_write(REG_CTRL, 32'h1);
    wait_idle(2000);
    wb_read(REG_STATUS, q);
    checks++; if (q !== 32'h0000_0308) begin errors++; $display("FAIL busy_start_status: got %h want 00000308", q); end
    for (int i = 0; i < 3; i++) begin
      wb_read(REG_FIFO, q);
      checks++; if (q !== ((32'(2 * i) << 16) | 32'd1)) begin errors++; $display("FAIL busy_start_entry%0d: got %h want %h", i, q, (32'(2 * i) << 16) | 32'd1); end
    end
    wb_write(REG_STATUS, 32'h8);
  endtask

  task automatic test_reset_mid_sweep();
    logic [31:0] q;
    hit_mode = 1;
    wb_write(REG_RANGE, (32'd31 << 16) | 32'd3);
    wb_write(REG_CFG, (32'd1 << 16) | 32'd1);
    wb_write(REG_CTRL, 32'h1);
    repeat (100) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (delay_code !== 10'd0) begin errors++; $display("FAIL midrst_code: got %0d want 0", delay_code); end
    checks++; if (meas_req !== 1'b0) begin errors++; $display("FAIL midrst_req: got %b want 0", meas_req); end
    wb_read(REG_STATUS, q);
    checks++; if (q !== 32'h2) begin errors++; $display("FAIL midrst_status: got %h want 00000002", q); end
    wb_read(REG_RANGE, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL midrst_range: got %h want 0", q); end
  endtask

  task automatic test_irq();
    logic [31:0] q;
    hit_mode = 1;
    wb_write(REG_RANGE, (32'd3 << 16) | 32'd3);
    wb_write(REG_CFG, (32'd1 << 16) | 32'd1);
    wb_write(REG_CTRL, 32'h4);
    wb_read(REG_CTRL, q);
`ifdef MU_SWEEP_IRQ_EN
    checks++; if (q !== 32'h4) begin errors++; $display("FAIL irq_en_read: got %h want 4", q); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_before: got %b want 0", irq); end
    wb_write(REG_CTRL, 32'h5);
    wait_idle(500);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_done: got %b want 1", irq); end
    wb_write(REG_STATUS, 32'h8);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b want 0", irq); end
    wb_write(REG_CTRL, 32'h0);
`else
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL irq_en_read: got %h want 0", q); end
    wb_write(REG_CTRL, 32'h5);
    wait_idle(500);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_tied: got %b want 0", irq); end
    checks++; if (irq_seen !== 1'b0) begin errors++; $display("FAIL irq_ever: got %b want 0", irq_seen); end
    wb_write(REG_STATUS, 32'h8);
`endif
    wb_read(REG_FIFO, q);
    checks++; if (q !== 32'h0003_0001) begin errors++; $display("FAIL irq_entry: got %h want 00030001", q); end
  endtask

  initial begin
    wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
    wb.adr = '0; wb.dat_w = '0; wb.sel = 4'h0;
    test_reset();
    test_basic();
    test_no_wrap();
    test_fifo_full();
    test_abort();
    test_start_rules();
    test_irq();
    test_reset_mid_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
